// File: rtl/reaction_pkg.sv
// ============================================================================
// Module      : reaction_pkg
// Description : Shared types and constants for the reaction-time game
//               controller: FSM state encoding, result width, LFSR seed,
//               LFSR tap mask and the LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        TIMING = 3'd2,
        RESULT = 3'd3,
        FOUL   = 3'd4
    } state_t;

    localparam int          MS_W      = 20;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
// ============================================================================
// Module      : ms_tick_gen
// Description : Millisecond tick generator. Counts 0..TICKS_PER_MS-1 and
//               pulses tick for one clk on the wrap. clear restarts the count
//               so the first tick lands TICKS_PER_MS clk after clear.
// Ports       : clk     - system clock
//               reset_n - asynchronous active-low reset
//               clear   - synchronous counter restart
//               tick    - one-clk pulse per millisecond
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_tick_gen #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW     = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [CW-1:0] c_last = CW'(TICKS_PER_MS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/reaction_ctrl.sv
// ============================================================================
// Module      : reaction_ctrl
// Description : Reaction-time game sequencer. A start press arms a random
//               pre-light delay, then the go LED lights and the player's
//               reaction is timed in ms. Results, false starts and timeouts
//               are latched for the display path.
//               Optional macro REACTION_BEST_TIME_EN tracks the best valid
//               time on best_ms; when undefined best_ms is tied to all ones.
// Ports       : clk, reset_n           - clock, async active-low reset
//               start_n, react_n       - raw active-low pushbuttons
//               led, busy, done        - go light / round active / result
//               false_start, timeout   - round-end qualifiers
//               ms_count [19:0]        - live or latched reaction time
//               best_ms  [19:0]        - best valid reaction time
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DLY_BITS     = 11,
    parameter int TIMEOUT_MS   = 999999
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_n,
    input  logic            react_n,
    output logic            led,
    output logic            busy,
    output logic            done,
    output logic            false_start,
    output logic            timeout,
    output logic [MS_W-1:0] ms_count,
    output logic [MS_W-1:0] best_ms
);

    localparam logic [MS_W-1:0] c_min_dly = MS_W'(MIN_DELAY_MS);
    localparam logic [MS_W-1:0] c_timeout = MS_W'(TIMEOUT_MS);

    if ((DLY_BITS < 1) || (DLY_BITS > 16) ||
        ((MIN_DELAY_MS + (1 << DLY_BITS) - 1) >= (1 << MS_W))) begin : g_dly_range_err
        $error("reaction_ctrl: MIN_DELAY_MS + 2**DLY_BITS - 1 must fit in dly_cnt");
    end
    if ((TIMEOUT_MS < 1) || (TIMEOUT_MS >= (1 << MS_W))) begin : g_timeout_range_err
        $error("reaction_ctrl: TIMEOUT_MS must lie in 1 .. 2**MS_W-1");
    end

    // Button synchronizers; idle level is high so they reset to 1.
    logic r_start_s1, r_start_s2, r_start_prev;
    logic r_react_s1, r_react_s2, r_react_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_s1   <= 1'b1;
            r_start_s2   <= 1'b1;
            r_start_prev <= 1'b1;
            r_react_s1   <= 1'b1;
            r_react_s2   <= 1'b1;
            r_react_prev <= 1'b1;
        end else begin
            r_start_s1   <= start_n;
            r_start_s2   <= r_start_s1;
            r_start_prev <= r_start_s2;
            r_react_s1   <= react_n;
            r_react_s2   <= r_react_s1;
            r_react_prev <= r_react_s2;
        end
    end

    logic w_start_press, w_react_press;
    assign w_start_press = r_start_prev & ~r_start_s2;
    assign w_react_press = r_react_prev & ~r_react_s2;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lfsr <= LFSR_SEED;
        else          r_lfsr <= lfsr_next(r_lfsr);
    end

    state_t          r_state;
    logic [MS_W-1:0] r_dly_cnt;
    logic            w_tick;
    logic            w_tick_clr;

    // The counter is held clear outside DELAY/TIMING, so entering DELAY
    // starts from zero; the DELAY->TIMING hand-off clears it explicitly.
    assign w_tick_clr = !((r_state == DELAY) || (r_state == TIMING)) ||
                        ((r_state == DELAY) && w_tick && (r_dly_cnt == MS_W'(1)));

    ms_tick_gen #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_tick_clr),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_dly_cnt   <= '0;
            ms_count    <= '0;
            led         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, RESULT, FOUL: begin
                    if (w_start_press) begin
                        r_state     <= DELAY;
                        r_dly_cnt   <= c_min_dly + MS_W'(r_lfsr[DLY_BITS-1:0]);
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                DELAY: begin
                    if (w_react_press) begin
                        r_state     <= FOUL;
                        busy        <= 1'b0;
                        false_start <= 1'b1;
                        ms_count    <= '0;
                    end else if (w_tick) begin
                        if (r_dly_cnt == MS_W'(1)) begin
                            r_state  <= TIMING;
                            led      <= 1'b1;
                            ms_count <= '0;
                        end else begin
                            r_dly_cnt <= r_dly_cnt - 1'b1;
                        end
                    end
                end
                TIMING: begin
                    if (w_react_press) begin
                        // ms_count keeps its registered value; a same-cycle tick is dropped.
                        r_state <= RESULT;
                        led     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (w_tick) begin
                        if (ms_count == (c_timeout - 1'b1)) begin
                            r_state  <= RESULT;
                            ms_count <= c_timeout;
                            led      <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            timeout  <= 1'b1;
                        end else begin
                            ms_count <= ms_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    led         <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    false_start <= 1'b0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_TIME_EN
    logic [MS_W-1:0] r_best;

    // Only a react-terminated round reaches RESULT with a valid time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_best <= '1;
        end else if ((r_state == TIMING) && w_react_press && (ms_count < r_best)) begin
            r_best <= ms_count;
        end
    end

    assign best_ms = r_best;
`else
    assign best_ms = '1;
`endif

endmodule

`default_nettype wire

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
Sequencing controller for the reaction-time game.
- On a start press it waits a pseudo-random delay, lights the go LED, then times the player's reaction in milliseconds.
- It latches the result and flags false starts and timeouts.
- It replaces free-running toggle control of the ms counter with a single clocked FSM. It drives the display/result path directly.

Parameters:
TICKS_PER_MS, 50000, clk cycles per 1 ms tick (50 MHz clock).
MIN_DELAY_MS, 1000, minimum pre-light delay in ms.
DLY_BITS, 11, number of LFSR bits added to the delay (random span 0..2^DLY_BITS-1 ms).
TIMEOUT_MS, 999999, reaction window; no press by then ends the round as a timeout.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start_n  input  1  start pushbutton, active-low, asynchronous to clk
react_n  input  1  reaction pushbutton, active-low, asynchronous to clk
led  output  1  go light, high only in TIMING
busy  output  1  high in DELAY or TIMING
done  output  1  high in RESULT
false_start  output  1  high in FOUL
timeout  output  1  high in RESULT when the round ended by TIMEOUT_MS
ms_count  output  20  result / live ms count
best_ms  output  20  best valid time (see Optional Feature)

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low on reset_n.
- Reset values: state=IDLE; led, busy, done, false_start, timeout=0; ms_count=0; best_ms=20'hFFFFF; LFSR=16'hACE1; tick counter=0.
- Reset mid-round aborts immediately to IDLE. No result is kept.
- Input capture:
  - Each button passes through a 2-flop synchronizer plus a previous-value flop.
  - A press is a 1->0 edge of the synchronized value.
  - A press is acted on 3 clk after the pin falls. Holding a button produces one press only.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clk in every state and never reaches 0.
- ms tick:
  - The tick counter counts 0..TICKS_PER_MS-1 and pulses tick on the wrap.
  - It is cleared on every entry to DELAY and TIMING, so the first tick arrives TICKS_PER_MS clk after entry.
- States and transitions:
  - IDLE: start press -> DELAY.
  - DELAY: on entry, dly_cnt = MIN_DELAY_MS + LFSR[DLY_BITS-1:0]; each tick decrements it.
    - react press -> FOUL. This has priority over expiry in the same cycle.
    - tick with dly_cnt==1 -> TIMING with ms_count=0.
    - start presses are ignored.
  - TIMING: led=1; each tick does ms_count+1.
    - react press -> RESULT. ms_count freezes at its current registered value; an increment coinciding with the press is dropped.
    - ms_count reaching TIMEOUT_MS on a tick -> RESULT with timeout=1, ms_count=TIMEOUT_MS.
    - react has priority over timeout in the same cycle.
  - RESULT: ms_count and timeout held; start press -> DELAY (new round; timeout clears, ms_count holds until TIMING).
  - FOUL: ms_count=0; start press -> DELAY.
- Simultaneous start and react presses: in DELAY/TIMING only react is considered; in IDLE/RESULT/FOUL only start is considered.
- Width rules:
  - ms_count is 20 bits, unsigned, and never wraps (TIMEOUT_MS < 2^20).
  - dly_cnt is 20 bits; MIN_DELAY_MS + 2^DLY_BITS - 1 must fit in 20 bits (elaboration check).

Optional Feature:
Macro REACTION_BEST_TIME_EN.
- Defined: on each entry to RESULT with timeout=0, best_ms <= min(best_ms, ms_count). Timeouts and fouls never update it. Cleared to 20'hFFFFF only by reset.
- Undefined: the best_ms port still exists and is tied to 20'hFFFFF; no comparator is synthesized.

Decomposition:
- Shared package reaction_pkg holds:
  - state encoding IDLE=0, DELAY=1, TIMING=2, RESULT=3, FOUL=4 (3-bit);
  - MS_W=20;
  - LFSR_SEED=16'hACE1 and the tap mask.
- One natural sub-module, ms_tick_gen: parameter TICKS_PER_MS, inputs clk/reset_n/clear, output tick. The FSM, synchronizers, LFSR and result registers stay in reaction_ctrl.

Test Plan (TICKS_PER_MS=4, MIN_DELAY_MS=5, DLY_BITS=3, TIMEOUT_MS=30):
- Reset then start press -> busy=1, led=0; led rises after 5..12 ticks (20..48 clk); the exact value matches the reference LFSR model.
- Normal round, react pressed 17 ticks after led rises -> done=1, led=0, ms_count=17, timeout=0, state RESULT.
- react press during DELAY -> false_start=1, led never rises, ms_count=0; next start press -> DELAY, false_start=0.
- No react press after led -> after 30 ticks timeout=1, done=1, ms_count=30; start and react in the same cycle in RESULT -> DELAY.
- react press coincident with a tick in TIMING at count 9 -> ms_count=9; react edge coincident with delay expiry -> FOUL.
- reset_n low mid-TIMING -> all outputs return to reset values asynchronously. With REACTION_BEST_TIME_EN, rounds of 17, 12 and a timeout -> best_ms=12.
